// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller and its ALU controller.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EXEC  = 4'd7,
    S_R_WB    = 4'd8,
    S_BRANCH  = 4'd9,
    S_I_EXEC  = 4'd10,
    S_I_WB    = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14
  } state_e;

  // Opcodes (IR[31:26]) and funct (IR[5:0])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU_OP codes consumed by the ALU controller
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  // Datapath mux selects
  localparam logic [1:0] RD_RT      = 2'b00;
  localparam logic [1:0] RD_RD      = 2'b01;
  localparam logic [1:0] RD_RA      = 2'b10;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] PC_REG     = 2'b11;

  // Unqualified control word; the top ANDs the *_req / *_wr_* fields with
  // Mem_Ready and Zero to form IRWrite and PC_En.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write_req;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_wr_ready;
    logic       pc_wr_branch;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_XORI);
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_LW) ||
           (op == OP_SW) || is_imm_alu(op);
  endfunction

endpackage

// File: rtl/main_ctrl_outputs.sv
// Pure state/opcode to control-word decoder for the main controller.
module main_ctrl_outputs
  import mips_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  output ctrl_t       ctrl_o
);

  logic [2:0] i_alu_op;
  logic       i_ext_op;

  // ALU op and immediate extension for the I-type ALU group
  always_comb begin
    i_ext_op = 1'b1;
    case (opcode_i)
      OP_SLTI: i_alu_op = ALU_SLT;
      OP_ANDI: begin i_alu_op = ALU_AND; i_ext_op = 1'b0; end
      OP_ORI:  begin i_alu_op = ALU_OR;  i_ext_op = 1'b0; end
      OP_XORI: begin i_alu_op = ALU_XOR; i_ext_op = 1'b0; end
      default: i_alu_op = ALU_ADD;
    endcase
  end

  // Moore decode: every field starts at its default, then each state sets its own
  always_comb begin
    ctrl_o        = '0;
    ctrl_o.ext_op = 1'b1;
    case (state_i)
      S_RESET: ctrl_o.ext_op = 1'b0;
      S_FETCH: begin
        ctrl_o.mem_read     = 1'b1;
        ctrl_o.alu_src_b    = SRCB_4;
        ctrl_o.alu_op       = ALU_ADD;
        ctrl_o.pc_src       = PC_ALU;
        ctrl_o.ir_write_req = 1'b1;
        ctrl_o.pc_wr_ready  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.illegal   = ~op_known(opcode_i);
      end
      S_MEM_ADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_dst    = RD_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst   = RD_RD;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a    = 1'b1;
        ctrl_o.alu_op       = ALU_SUB;
        ctrl_o.pc_src       = PC_ALUOUT;
        ctrl_o.pc_wr_branch = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = i_alu_op;
        ctrl_o.ext_op    = i_ext_op;
      end
      S_I_WB: begin
        ctrl_o.reg_dst   = RD_RT;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = i_alu_op;
        ctrl_o.ext_op    = i_ext_op;
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      S_JAL: begin
        ctrl_o.pc_src     = PC_JUMP;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.reg_dst    = RD_RA;
        ctrl_o.mem_to_reg = M2R_PC;
        ctrl_o.reg_write  = 1'b1;
      end
      S_JR: begin
        ctrl_o.pc_src   = PC_REG;
        ctrl_o.pc_write = 1'b1;
      end
      default: ctrl_o.ext_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_controller.sv
// Multi-cycle MIPS sequencing FSM: state register, next-state logic and
// Mem_Ready/Zero qualification of IRWrite and PC_En.
module main_controller
  import mips_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [2:0] ALU_OP,
  output logic [1:0] PCSrc,
  output logic       PC_En,
  output logic       Illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // State register; reset forces RESET immediately so every output drops to 0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  // Next state; Mem_Ready only matters in the three wait states
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = Mem_Ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADR;
          OP_RTYPE:       state_d = (Funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default:        state_d = is_imm_alu(Opcode) ? S_I_EXEC : S_FETCH;
        endcase
      end
      S_MEM_ADR: state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = Mem_Ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_d = Mem_Ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:  state_d = S_R_WB;
      S_I_EXEC:  state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  main_ctrl_outputs u_dec (
    .state_i  (state_q),
    .opcode_i (Opcode),
    .ctrl_o   (ctrl)
  );

  assign IorD     = ctrl.iord;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ExtOp    = ctrl.ext_op;
  assign ALU_OP   = ctrl.alu_op;
  assign PCSrc    = ctrl.pc_src;
  assign Illegal  = ctrl.illegal;

  // IR and PC+4 load only on the cycle the fetch completes; branches take
  // Zero for beq and its complement for bne.
  assign IRWrite = ctrl.ir_write_req & Mem_Ready;
  assign PC_En   = ctrl.pc_write
                 | (ctrl.pc_wr_ready & Mem_Ready)
                 | (ctrl.pc_wr_branch & (Zero ^ (Opcode == OP_BNE)));

endmodule

// File: tb/tb_main_controller.sv
// Self-checking bench for main_controller: directed instruction sequences plus
// randomized instructions, stalls and Zero, compared cycle by cycle against an
// instruction-level model of the expected control outputs.
module tb_main_controller;

  typedef struct packed {
    logic       iord, mrd, mwr, irw;
    logic [1:0] rdst, m2r;
    logic       rw, srca;
    logic [1:0] srcb;
    logic       ext;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       pcen, ill;
  } o_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] Opcode = '0, Funct = '0;
  logic       Zero = 1'b0, Mem_Ready = 1'b0;
  logic       IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtOp, PC_En, Illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic [2:0] ALU_OP;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  main_controller dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Mem_Ready(Mem_Ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALU_OP(ALU_OP),
    .PCSrc(PCSrc), .PC_En(PC_En), .Illegal(Illegal)
  );

  o_t obs;
  assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ExtOp, ALU_OP, PCSrc, PC_En, Illegal};

  function automatic o_t base();
    o_t e = '0;
    e.ext = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input o_t e);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs, e);
    end
  endtask

  // One clock cycle: entered at posedge+1, samples on the falling edge
  task automatic cyc(input logic mr, input o_t e, input string tag);
    Mem_Ready = mr;
    @(negedge CLK);
    chk(tag, e);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    chk("rst_async", '0);
    @(negedge CLK);
    chk("rst_hold", '0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc(1'b1, '0, "reset_state");
  endtask

  // Expected per-cycle outputs of one instruction, derived from its class.
  // fs/ms: Mem_Ready=0 cycles in FETCH and in the memory access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fs, input int ms, input bit abort);
    o_t e;
    bit lw, sw, jr, rr, br, ia, jj, jl, ill;
    logic [2:0] iop;
    logic iext;
    Opcode = op; Funct = fn; Zero = z;
    lw = (op == 6'h23); sw = (op == 6'h2b);
    jr = (op == 6'h00) && (fn == 6'h08);
    rr = (op == 6'h00) && !jr;
    br = (op == 6'h04) || (op == 6'h05);
    ia = (op >= 6'h08) && (op <= 6'h0e) && (op != 6'h0b);
    jj = (op == 6'h02); jl = (op == 6'h03);
    ill = !(lw || sw || jr || rr || br || ia || jj || jl);
    case (op)
      6'h0a:   begin iop = 3'b011; iext = 1'b1; end
      6'h0c:   begin iop = 3'b100; iext = 1'b0; end
      6'h0d:   begin iop = 3'b101; iext = 1'b0; end
      6'h0e:   begin iop = 3'b110; iext = 1'b0; end
      default: begin iop = 3'b000; iext = 1'b1; end
    endcase

    for (int i = 0; i <= fs; i++) begin
      e = base(); e.mrd = 1; e.srcb = 2'b01;
      e.irw = (i == fs); e.pcen = (i == fs);
      cyc(i == fs, e, "fetch");
    end
    e = base(); e.srcb = 2'b11; e.ill = ill;
    cyc(1'($urandom), e, ill ? "decode_illegal" : "decode");

    if (lw || sw) begin
      e = base(); e.srca = 1; e.srcb = 2'b10;
      cyc(1'($urandom), e, "mem_adr");
      for (int i = 0; i <= ms; i++) begin
        e = base(); e.iord = 1;
        if (lw) e.mrd = 1; else e.mwr = 1;
        if (abort) begin
          cyc(1'b0, e, "mem_rd_before_abort");
          do_reset();
          return;
        end
        cyc(i == ms, e, lw ? "mem_rd" : "mem_wr");
      end
      if (lw) begin
        e = base(); e.m2r = 2'b01; e.rw = 1;
        cyc(1'($urandom), e, "mem_wb");
      end
    end else if (rr) begin
      e = base(); e.srca = 1; e.aop = 3'b010;
      cyc(1'($urandom), e, "r_exec");
      e = base(); e.rdst = 2'b01; e.rw = 1;
      cyc(1'($urandom), e, "r_wb");
    end else if (br) begin
      e = base(); e.srca = 1; e.aop = 3'b001; e.pcs = 2'b01;
      e.pcen = (op == 6'h04) ? z : !z;
      cyc(1'($urandom), e, (op == 6'h04) ? "beq" : "bne");
    end else if (ia) begin
      e = base(); e.srca = 1; e.srcb = 2'b10; e.aop = iop; e.ext = iext;
      cyc(1'($urandom), e, "i_exec");
      e = base(); e.rw = 1; e.aop = iop; e.ext = iext;
      cyc(1'($urandom), e, "i_wb");
    end else if (jj || jl || jr) begin
      e = base(); e.pcen = 1; e.pcs = jr ? 2'b11 : 2'b10;
      if (jl) begin e.rdst = 2'b10; e.m2r = 2'b10; e.rw = 1; end
      cyc(1'($urandom), e, jr ? "jr" : (jl ? "jal" : "j"));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [16];
    logic [5:0] op, fn;
    ops = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09,
            6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h02, 6'h03, 6'h3f, 6'h11};

    // Reset held, then released: one RESET cycle before the first FETCH
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", '0);
    RST = 1'b1;
    cyc(1'b1, '0, "reset_state");

    // Directed sequence
    run_instr(6'h23, 6'h00, 1'b0, 0, 0, 0);   // lw, zero wait
    run_instr(6'h2b, 6'h00, 1'b0, 0, 3, 0);   // sw, 3 stall cycles in MEM_WR
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0);   // beq taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, 0);   // bne not taken
    run_instr(6'h0d, 6'h00, 1'b0, 0, 0, 0);   // ori
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, 0);   // jal
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, 0);   // jr
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0, 0);   // illegal
    run_instr(6'h23, 6'h00, 1'b0, 2, 2, 0);   // lw with fetch and read stalls
    run_instr(6'h23, 6'h00, 1'b0, 0, 1, 1);   // lw aborted by reset in MEM_RD
    run_instr(6'h00, 6'h20, 1'b0, 1, 0, 0);   // R-type after restart

    // Randomized instructions, stalls and Zero
    for (int k = 0; k < 60; k++) begin
      op = (k % 7 == 6) ? 6'($urandom) : ops[$urandom_range(0, 15)];
      fn = ($urandom_range(0, 1) == 1) ? 6'h08 : 6'($urandom);
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_controller.md
# main_controller

Multi-cycle sequencing FSM for the MIPS datapath. It decodes the IR opcode (and the funct field for jr) and steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath mux and write strobe, plus the 3-bit ALU_OP consumed by the ALU controller. It stalls on a memory-ready handshake and generates the qualified PC enable internally.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- Opcode  in  6  IR[31:26]; stable outside FETCH
- Funct  in  6  IR[5:0]; used only to detect jr (001000)
- Zero  in  1  ALU zero flag
- Mem_Ready  in  1  memory access completes this cycle
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead / MemWrite  out  1 each  memory strobes
- IRWrite  out  1  IR load
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend immediate
- ALU_OP  out  3  to ALU controller: 000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or, 110 xor
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- PC_En  out  1  qualified PC write
- Illegal  out  1  one-cycle pulse on unknown opcode

## Operation
- Moore FSM; all outputs decode from the state register only, except PC_En, IRWrite and the wait conditions, which also use Zero and Mem_Ready.
- Default for every output in every state: 0; ExtOp default 1.
- States and their outputs:
  - RESET: all outputs 0; entered asynchronously; always goes to FETCH.
  - FETCH: MemRead, ALUSrcB=01, ALU_OP=000, PCSrc=00. IRWrite and PC_En are asserted only when Mem_Ready=1. Holds while Mem_Ready=0; goes to DECODE when it is 1.
  - DECODE: ALUSrcB=11, ALU_OP=000 (computes the branch target). Next state by opcode:
    - lw (100011) or sw (101011): MEM_ADR
    - 000000 with Funct=001000: JR
    - other 000000: R_EXEC
    - beq (000100) or bne (000101): BRANCH
    - addi/addiu/slti/andi/ori/xori (001000/001001/001010/001100/001101/001110): I_EXEC
    - j (000010): JUMP
    - jal (000011): JAL
    - anything else: FETCH, with Illegal=1 for this cycle.
  - MEM_ADR: ALUSrcA=1, ALUSrcB=10, ALU_OP=000. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: IorD, MemRead. Holds until Mem_Ready, then goes to MEM_WB.
  - MEM_WB: RegDst=00, MemtoReg=01, RegWrite. Goes to FETCH.
  - MEM_WR: IorD, MemWrite. Holds until Mem_Ready, then goes to FETCH.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_OP=010. Goes to R_WB.
  - R_WB: RegDst=01, RegWrite. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALU_OP=001, PCSrc=01. PC_En = Zero for beq, ~Zero for bne. Goes to FETCH.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10. ALU_OP: 000 for addi/addiu, 011 for slti, 100/101/110 for andi/ori/xori. ExtOp=0 for andi/ori/xori. Goes to I_WB.
  - I_WB: RegDst=00, RegWrite. Keeps the ALU_OP and ExtOp of I_EXEC. Goes to FETCH.
  - JUMP: PCSrc=10, PC_En. Goes to FETCH.
  - JAL: PCSrc=10, PC_En, RegDst=10, MemtoReg=10, RegWrite. Goes to FETCH.
  - JR: PCSrc=11, PC_En. Goes to FETCH.
- JAL writes the PC value before this cycle's update (already PC+4 from FETCH). The datapath captures it at the same edge.

## Timing
- Reset: state=RESET and every output 0 while RST=0. First FETCH is one cycle after RST deasserts.
- Cycles per instruction, with zero wait states: lw 5, sw 4, R-type 4, I-ALU 4, beq/bne 3, j/jal/jr 3. Each Mem_Ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Mem_Ready outside FETCH, MEM_RD and MEM_WR is ignored.
- RST asserted mid-instruction aborts it: outputs go to 0 immediately (asynchronously), and no partial write strobe survives the edge.
- Illegal opcode costs 2 cycles (FETCH, DECODE) and does not write the PC beyond the +4.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum
  - opcode and funct constants
  - ALU_OP codes (shared with the ALU controller)
  - RegDst, MemtoReg, ALUSrcB and PCSrc select encodings
- Sub-module main_ctrl_outputs: a pure state/opcode-to-output decoder. The top level keeps the state register, the next-state logic and the PC_En qualification.

## Test plan
- Reset release, then lw (Opcode=100011) with Mem_Ready=1 -> states RESET, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; RegWrite=1 with MemtoReg=01 in cycle 5 only.
- sw with Mem_Ready low for 3 cycles in MEM_WR -> MemWrite=1 held for 4 cycles; FETCH follows the Mem_Ready=1 cycle.
- beq with Zero=1, then bne with Zero=1 -> PC_En=1 in beq's BRANCH; PC_En=0 in bne's BRANCH; ALU_OP=001 in both.
- ori (001101) -> I_EXEC and I_WB show ALU_OP=101, ExtOp=0, RegDst=00; RegWrite=1 only in I_WB.
- jal, then Funct=001000 R-type -> JAL drives RegDst=10, MemtoReg=10, PCSrc=10; JR drives PCSrc=11; each takes 3 cycles.
- Opcode=111111, and a separate run with RST pulsed low in MEM_RD -> Illegal=1 for one DECODE cycle, then FETCH; on the reset run all outputs are 0 asynchronously and the FSM restarts at RESET.
